clock_div_multi: RTL
====================

// Module: clock_div_multi
// PURPOSE
//   N-channel programmable clock divider; successor to the single fixed-ratio divider.
//   Each channel produces a divided level output (clk_out) and a one-cycle tick on each rising edge.
//   Per-channel half-period is reprogrammable at runtime through a valid/ready config port.
//   Reprogramming is glitch-free: a new value is taken only at a phase boundary.
//   Sits beside the game FSMs; drives slow display/animation clocks and tick enables.
// PARAMETERS
//   NUM_CH        4           number of independent channels (>=1)
//   CNT_W         26          counter/divisor width in bits
//   DEFAULT_HALF  25_000_000  reset half-period in clk_in cycles, all channels (1 Hz @ 50 MHz)
// PORTS
//   clk_in     in   1                  sole clock
//   rst        in   1                  synchronous, active-high reset
//   ch_en      in   NUM_CH             per-channel run enable
//   sync       in   1                  one-cycle pulse: phase-align all channels
//   cfg_valid  in   1                  config request
//   cfg_ready  out  1                  config can be accepted for cfg_ch
//   cfg_ch     in   max(1,$clog2(NUM_CH))  target channel
//   cfg_half   in   CNT_W              new high-phase length (cycles)
//   cfg_low    in   CNT_W              new low-phase length (only when CLK_DIV_DUTY_EN)
//   clk_out    out  NUM_CH             divided clock levels, registered
//   tick       out  NUM_CH             1-cycle strobe, high in the cycle clk_out[i] goes 0->1
// BEHAVIOUR
//   - Reset: clk_out=0, tick=0, counters=0, active hi/lo=DEFAULT_HALF, pending=0, cfg_ready=0.
//   - Per channel, enabled: cnt increments each cycle; when cnt==phase_len-1:
//       cnt<=0, clk_out toggles, phase_len switches to hi or lo length for the new level.
//   - First rise occurs DEFAULT_HALF (or active lo) cycles after the first enabled cycle.
//   - Length value 0 treated as 1 (toggle every cycle); no other clamping.
//   - ch_en[i]=0: next cycle cnt=0, clk_out=0, tick=0; a pending config applies immediately.
//   - Config: accept when cfg_valid & cfg_ready; cfg_ready = ~rst & ~pending[cfg_ch].
//       Accepted value goes to channel's shadow (pending=1). Shadow copies to active
//       when clk_out falls 1->0 (end of period) or channel disabled; pending clears same cycle.
//       cfg_ch >= NUM_CH: accepted and discarded.
//   - sync=1: all channels next cycle cnt=0, clk_out=0, tick=0; pending shadows applied.
//       cfg accepted in the same cycle as sync stays pending (not applied by that sync).
//   - Priority per channel: rst > sync > ~ch_en > count/toggle.
//   - tick is registered with clk_out (zero skew); never two ticks closer than hi+lo cycles.
//   - rst mid-period: all state returns to reset values next cycle; in-flight config lost.
// CONFIGURATION
//   CLK_DIV_DUTY_EN defined: cfg_low port exists; high phase = cfg_half, low phase = cfg_low.
//   Undefined: no cfg_low port; low phase = high phase = cfg_half (50% duty).
//   Reset values of both lengths = DEFAULT_HALF in either build.
// STRUCTURE
//   clock_div_pkg: cnt_t typedef (logic [CNT_W-1:0] via parameter), chan_cfg_t struct
//     {hi, lo}, DEFAULT_HALF-derived reset constant.
//   clock_div_chan: one channel (counter, level, tick, shadow/pending); top generates
//     NUM_CH instances plus config decode and cfg_ready mux.
// TESTING (NUM_CH=2, CNT_W=8, DEFAULT_HALF=3 unless noted)
//   1. rst 2 cycles, ch_en=2'b11 -> clk_out[0] rises at cycle 3 after rst low, period 6, tick 1 cycle/rise.
//   2. cfg ch0 half=5 mid high phase -> current period finishes at 3/3, next period 5/5; cfg_ready[ch0] low until applied.
//   3. Second cfg to ch0 while pending -> cfg_ready=0, request held, accepted after apply cycle.
//   4. ch_en[1]=0 for 4 cycles then 1 -> clk_out[1]=0 during, first rise 3 cycles after re-enable; ch0 unaffected.
//   5. sync pulse with channels at different phases -> both clk_out=0 next cycle, rise together 3 cycles later.
//   6. DUTY_EN build: half=2, low=6 -> clk_out high 2, low 6, period 8; half=0 -> high 1 cycle.

Source files
------------

// File: rtl/clock_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// A package cannot take parameters. The width-dependent types cnt_t and
// chan_cfg_t are therefore declared in clock_div_chan from its CNT_W
// parameter. This package holds the default sizes and the select-width helper.
package clock_div_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 26;
    localparam int DEF_HALF   = 25_000_000;   // 1 Hz at 50 MHz

    // The channel-select field stays at least one bit wide, even for one channel.
    function automatic int ch_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: phase counter, output level, rise tick and a
// shadow/pending config register.
// A new config reaches the active lengths only at a period boundary, which
// is the falling edge of the output, or when the channel is forced low.
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_cfg_we,
    input  logic [CNT_W-1:0] i_cfg_hi,
    input  logic [CNT_W-1:0] i_cfg_lo,
    output logic             o_pending,
    output logic             o_clk,
    output logic             o_tick
);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef struct packed {
        cnt_t hi;
        cnt_t lo;
    } chan_cfg_t;

    localparam cnt_t      RST_LEN = cnt_t'(DEFAULT_HALF);
    localparam chan_cfg_t RST_CFG = '{hi: RST_LEN, lo: RST_LEN};

    cnt_t      r_cnt;
    logic      r_clk;
    logic      r_tick;
    logic      r_pending;
    chan_cfg_t r_act;
    chan_cfg_t r_shadow;

    cnt_t      w_len;
    cnt_t      w_last;
    logic      w_wrap;
    logic      w_fall;
    logic      w_apply;

    // Select the length of the current phase. A length of 0 behaves like 1.
    always_comb begin
        w_len   = r_clk ? r_act.hi : r_act.lo;
        w_last  = (w_len == '0) ? '0 : (w_len - cnt_t'(1));
        w_wrap  = (r_cnt == w_last);
        w_fall  = i_en && !i_sync && w_wrap && r_clk;
        w_apply = r_pending && (i_sync || !i_en || w_fall);
    end

    // Counter and level. Sync and disable both restart the channel low.
    // The tick is registered together with the level, so there is no skew.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (i_sync || !i_en) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_clk  <= ~r_clk;
            r_tick <= ~r_clk;
        end else begin
            r_cnt  <= r_cnt + cnt_t'(1);
            r_tick <= 1'b0;
        end
    end

    // Shadow config. A write is only issued while nothing is pending, so a
    // write and an apply never collide. A write issued together with a sync
    // stays pending until the next boundary.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_act     <= RST_CFG;
            r_shadow  <= RST_CFG;
            r_pending <= 1'b0;
        end else if (i_cfg_we) begin
            r_shadow  <= '{hi: i_cfg_hi, lo: i_cfg_lo};
            r_pending <= 1'b1;
        end else if (w_apply) begin
            r_act     <= r_shadow;
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;
    assign o_clk     = r_clk;
    assign o_tick    = r_tick;

endmodule

// File: rtl/clock_div_multi.sv
// N-channel programmable clock divider with glitch-free runtime reprogramming.
// Build option CLK_DIV_DUTY_EN adds the cfg_low port, which gives each
// channel an independent low-phase length. Without it, both phases use cfg_half.
module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter  int NUM_CH       = DEF_NUM_CH,
    parameter  int CNT_W        = DEF_CNT_W,
    parameter  int DEFAULT_HALF = DEF_HALF,
    localparam int CH_W         = ch_sel_w(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
`ifdef CLK_DIV_DUTY_EN
    input  logic [CNT_W-1:0]  cfg_low,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_cfg_we;
    logic              w_sel_pending;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cfg_lo;

`ifdef CLK_DIV_DUTY_EN
    assign w_cfg_lo = cfg_low;
`else
    assign w_cfg_lo = cfg_half;
`endif

    // Decode the target channel. A channel number with no channel behind it
    // selects nothing, so the request is accepted and then dropped.
    always_comb begin
        w_sel_pending = 1'b0;
        w_cfg_we      = '0;
        w_accept      = cfg_valid && cfg_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cfg_ch) == i) begin
                w_sel_pending = w_pending[i];
                w_cfg_we[i]   = w_accept;
            end
        end
    end

    assign cfg_ready = !rst && !w_sel_pending;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_div_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clk_in    (clk_in),
            .rst       (rst),
            .i_en      (ch_en[g]),
            .i_sync    (sync),
            .i_cfg_we  (w_cfg_we[g]),
            .i_cfg_hi  (cfg_half),
            .i_cfg_lo  (w_cfg_lo),
            .o_pending (w_pending[g]),
            .o_clk     (clk_out[g]),
            .o_tick    (tick[g])
        );
    end

endmodule
